// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to imem and
// buffers in-order responses in a small FIFO for the single-cycle datapath.
module fetch_unit #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     ILEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);
  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(BUF_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic            err_q, err_d;
  logic [ILEN-1:0] data_mem_q [BUF_DEPTH];
  logic [XLEN-1:0] pc_mem_q   [BUF_DEPTH];

  logic            req_fire, resp_ok, push, pop;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] target_pc;

  // Issue decision uses only registered counts, so resp/pop never reach req_valid.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_ok        = imem_resp_valid && (inflight_q != '0);
  assign push           = resp_ok && (drop_q == '0) && !redirect_valid;
  assign inst_valid     = (count_q != '0);
  assign pop            = inst_valid && inst_ready;
  assign inst_data      = inst_valid ? data_mem_q[rd_ptr_q] : '0;
  assign inst_pc        = inst_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign fetch_err      = err_q;
  assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    err_d      = err_q || (imem_resp_valid && (inflight_q == '0));
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = inflight_q - CW'(resp_ok);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + WORD_STEP;
      if (resp_ok && (drop_q != '0)) drop_d = drop_q - CNT_ONE;
      if (push) begin
        resp_pc_d = resp_pc_q + WORD_STEP;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem_q[wr_ptr_q] <= imem_resp_data;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based imem model, per-cycle vector table, directed
// redirect/stall/error sequences and a randomized run against a PC-stream model.
module tb_fetch_unit;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RPC = 64'h0;

  logic clk = 1'b0;
  logic reset, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic inst_valid, inst_ready, redirect_valid, fetch_err;
  logic [63:0] imem_req_addr, inst_pc, redirect_pc;
  logic [31:0] imem_resp_data, inst_data;

  fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int unsigned lat_lo = 1, lat_hi = 1;
  logic [31:0] dmask = '0;
  bit force_resp = 0, mem_out = 0;

  bit model_on = 0;
  logic [63:0] exp_pc = '0;
  int consumed = 0;
  bit hold_pending = 0;
  logic [63:0] hold_addr = '0;

  bit g_rst = 1, g_rr = 0, g_ir = 0, g_rv = 0;
  logic [63:0] g_rpc = '0;

  typedef struct {
    bit rst, rr, ir, chk, e_rv;
    logic [63:0] e_addr;
    bit e_iv;
    logic [63:0] e_pc;
  } vec_t;
  vec_t tv[$];

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ dmask;
  endfunction

  function automatic vec_t vec(input bit rst, rr, ir, chk, e_rv, input logic [63:0] e_addr,
                               input bit e_iv, input logic [63:0] e_pc);
    vec_t v;
    v.rst = rst; v.rr = rr; v.ir = ir; v.chk = chk; v.e_rv = e_rv;
    v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe the settled cycle, advance, then drive the next cycle.
  task automatic step();
    bit acc, pop;
    logic [63:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    pop = inst_valid && inst_ready;
    if (hold_pending && imem_req_valid) check("addr_hold", imem_req_addr, hold_addr);
    hold_pending = imem_req_valid && !imem_req_ready;
    hold_addr    = imem_req_addr;
    if (model_on) begin
      if (pop) begin
        check("stream_pc", inst_pc, exp_pc);
        check("stream_data", {32'h0, inst_data}, {32'h0, word_of(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_out) void'(mq.pop_front());
    if (acc) mq.push_back('{addr: a, due: cyc - 1 + int'($urandom_range(lat_hi, lat_lo))});
    if (g_rst) mq.delete();
    mem_out = (mq.size() > 0) && (mq[0].due <= cyc);
    reset           = g_rst;
    imem_req_ready  = g_rr;
    inst_ready      = g_ir;
    redirect_valid  = g_rv;
    redirect_pc     = g_rpc;
    imem_resp_valid = mem_out || force_resp;
    imem_resp_data  = mem_out ? word_of(mq[0].addr) : $urandom;
    #1;
  endtask

  task automatic do_reset();
    g_rst = 1; g_rv = 0; force_resp = 0;
    step(); step();
    g_rst = 0;
  endtask

  initial begin
    bit found;
    reset = 1; imem_req_ready = 0; inst_ready = 0; redirect_valid = 0;
    redirect_pc = '0; imem_resp_valid = 0; imem_resp_data = '0;

    do_reset();
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_fetch_err", fetch_err, 0);

    // Streaming with ready high, reset, then a full-buffer stall and drain.
    tv.push_back(vec(0,1,1,1, 1,64'h00, 0,0));
    tv.push_back(vec(0,1,1,1, 1,64'h04, 0,0));
    tv.push_back(vec(0,1,1,1, 1,64'h08, 1,64'h00));
    tv.push_back(vec(0,1,1,1, 1,64'h0c, 1,64'h04));
    tv.push_back(vec(0,1,1,1, 1,64'h10, 1,64'h08));
    tv.push_back(vec(0,1,1,1, 1,64'h14, 1,64'h0c));
    tv.push_back(vec(1,1,1,0, 0,0, 0,0));
    tv.push_back(vec(1,1,1,1, 0,0, 0,0));
    tv.push_back(vec(0,1,0,1, 1,64'h00, 0,0));
    tv.push_back(vec(0,1,0,1, 1,64'h04, 0,0));
    tv.push_back(vec(0,1,0,1, 1,64'h08, 1,64'h00));
    tv.push_back(vec(0,1,0,1, 1,64'h0c, 1,64'h00));
    tv.push_back(vec(0,1,0,1, 0,0, 1,64'h00));
    tv.push_back(vec(0,1,0,1, 0,0, 1,64'h00));
    tv.push_back(vec(0,1,1,1, 0,0, 1,64'h00));
    tv.push_back(vec(0,1,1,1, 1,64'h10, 1,64'h04));
    tv.push_back(vec(0,1,1,1, 1,64'h14, 1,64'h08));
    tv.push_back(vec(0,1,1,1, 1,64'h18, 1,64'h0c));
    tv.push_back(vec(0,1,1,1, 1,64'h1c, 1,64'h10));
    foreach (tv[i]) begin
      g_rst = tv[i].rst; g_rr = tv[i].rr; g_ir = tv[i].ir;
      step();
      if (tv[i].chk) begin
        check($sformatf("tbl%0d_req_valid", i), imem_req_valid, tv[i].e_rv);
        if (tv[i].e_rv) check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tv[i].e_addr);
        check($sformatf("tbl%0d_inst_valid", i), inst_valid, tv[i].e_iv);
        if (tv[i].e_iv) begin
          check($sformatf("tbl%0d_inst_pc", i), inst_pc, tv[i].e_pc);
          check($sformatf("tbl%0d_inst_data", i), inst_data, tv[i].e_pc[31:0]);
        end
      end
    end
    check("tbl_fetch_err", fetch_err, 0);

    // 5-cycle memory, redirect with three requests outstanding.
    do_reset();
    lat_lo = 5; lat_hi = 5; g_rr = 1; g_ir = 1;
    step(); step(); step();
    g_rv = 1; g_rpc = 64'h100;
    step();
    check("redirA_no_req", imem_req_valid, 0);
    g_rv = 0;
    step();
    check("redirA_req_valid", imem_req_valid, 1);
    check("redirA_req_addr", imem_req_addr, 64'h100);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (inst_valid) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redirA_timeout actual=no inst_valid required=inst_valid within 40 cycles");
    end else begin
      check("redirA_first_pc", inst_pc, 64'h100);
      check("redirA_first_data", inst_data, 32'h100);
    end

    // Redirect to a misaligned target coincident with a response and a pop.
    do_reset();
    lat_lo = 1; lat_hi = 1; g_rr = 1; g_ir = 1;
    step(); step(); step();
    g_rv = 1; g_rpc = 64'h203;
    step();
    check("redirB_no_req", imem_req_valid, 0);
    check("redirB_pop_valid", inst_valid, 1);
    g_rv = 0;
    step();
    check("redirB_req_addr", imem_req_addr, 64'h200);
    check("redirB_flushed", inst_valid, 0);
    step();
    check("redirB_drop_resp", inst_valid, 0);
    step();
    check("redirB_valid", inst_valid, 1);
    check("redirB_pc", inst_pc, 64'h200);
    check("redirB_data", inst_data, 32'h200);
    step();
    check("redirB_next_pc", inst_pc, 64'h204);

    // Memory not ready for three cycles while addr 0x8 is pending.
    do_reset();
    g_rr = 1; g_ir = 1;
    step(); check("stall_addr0", imem_req_addr, 64'h0);
    step(); check("stall_addr1", imem_req_addr, 64'h4);
    g_rr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", imem_req_valid, 1);
      check("stall_addr", imem_req_addr, 64'h8);
    end
    g_rr = 1;
    step(); check("stall_release", imem_req_addr, 64'h8);
    step(); check("stall_advance", imem_req_addr, 64'hc);

    // Spurious response, sticky error, then reset mid-stream.
    do_reset();
    g_rr = 0; g_ir = 1;
    step(); step();
    force_resp = 1;
    step();
    force_resp = 0;
    step();
    check("err_set", fetch_err, 1);
    check("err_fifo_empty", inst_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("err_sticky", fetch_err, 1);
    end
    g_rr = 1;
    step(); step(); step();
    check("err_stream_valid", inst_valid, 1);
    check("err_stream_pc", inst_pc, 64'h0);
    check("err_still_set", fetch_err, 1);
    lat_lo = 5; lat_hi = 5;
    step(); step(); step();
    g_rst = 1;
    step();
    check("mrst_req_valid", imem_req_valid, 0);
    step();
    check("mrst_inst_valid", inst_valid, 0);
    check("mrst_inst_pc", inst_pc, 0);
    check("mrst_inst_data", inst_data, 0);
    check("mrst_fetch_err", fetch_err, 0);
    g_rst = 0;
    step();
    check("mrst_restart_valid", imem_req_valid, 1);
    check("mrst_restart_addr", imem_req_addr, RPC);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (inst_valid) found = 1;
    end
    check("mrst_first_pc", found ? inst_pc : 64'hdead, RPC);

    // Randomized traffic against the expected in-order PC stream.
    do_reset();
    dmask = 32'hc3a5_5a3c;
    lat_lo = 1; lat_hi = 1;
    exp_pc = RPC; consumed = 0; model_on = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 256 == 0) lat_hi = $urandom_range(6, 1);
      g_rr = ($urandom % 4) != 0;
      g_ir = ($urandom % 4) != 0;
      g_rv = ($urandom % 20) == 0;
      g_rpc = {$urandom, $urandom};
      if ($urandom % 4 == 0) g_rpc = 64'hffff_ffff_ffff_fff0 | 64'($urandom % 16);
      step();
    end
    model_on = 0;
    checks++;
    if (consumed < 300) begin
      errors++;
      $display("FAIL rand_progress actual=%0d required>=300", consumed);
    end
    check("rand_fetch_err", fetch_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
